// File: rtl/image_phase_scheduler_if.sv
// Engine-side and image-memory-side signals of the phase scheduler.
// master = scheduler, slave = engines plus memory.
interface image_phase_scheduler_if #(
   parameter int ADDR_W = 6,
   parameter int PIX_W  = 24
);
   logic [2:0]          eng_start;
   logic [2:0]          eng_done;
   logic [3*ADDR_W-1:0] eng_row;
   logic [3*ADDR_W-1:0] eng_col;
   logic [2:0]          eng_we;
   logic [3*PIX_W-1:0]  eng_pix;
   logic [ADDR_W-1:0]   row;
   logic [ADDR_W-1:0]   col;
   logic                we;
   logic [PIX_W-1:0]    out_pix;

   modport master (
      output eng_start, row, col, we, out_pix,
      input  eng_done, eng_row, eng_col, eng_we, eng_pix
   );

   modport slave (
      input  eng_start, row, col, we, out_pix,
      output eng_done, eng_row, eng_col, eng_we, eng_pix
   );
endinterface

// File: rtl/image_phase_scheduler.sv
// Runs gray -> compress -> encode and muxes the active engine onto the image-memory port.
// One-cycle registered latency on every output; no backpressure, engines pace themselves via eng_done.
module image_phase_scheduler #(
   parameter int ADDR_W  = 6,
   parameter int PIX_W   = 24,
   parameter int TIMEOUT = 65536
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   image_phase_scheduler_if.master bus,
   output logic                   gray_done,
   output logic                   compress_done,
   output logic                   encode_done,
   output logic                   busy,
   output logic                   err
);
   localparam int              WD_W    = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE, G_ST, G_RUN, C_ST, C_RUN, E_ST, E_RUN, DONE, ERROR
   } state_t;

   state_t state, state_nxt;

   logic [WD_W-1:0]   wdog, wdog_nxt;
   logic [2:0]        done_q, done_nxt;
   logic [2:0]        eng_start_nxt;
   logic              busy_nxt, err_nxt;
   logic [2:0]        act_sel;
   logic              in_run, act_done, wd_expired, start_ok, fwd;
   logic [ADDR_W-1:0] act_row, act_col;
   logic [PIX_W-1:0]  act_pix;
   logic              act_we;

   assign gray_done     = done_q[0];
   assign compress_done = done_q[1];
   assign encode_done   = done_q[2];

   // Which engine owns the current phase, and the qualifiers derived from it.
   always_comb begin
      act_sel = 3'b000;
      case (state)
         G_ST, G_RUN: act_sel = 3'b001;
         C_ST, C_RUN: act_sel = 3'b010;
         E_ST, E_RUN: act_sel = 3'b100;
         default:     act_sel = 3'b000;
      endcase
   end

   assign in_run     = (state == G_RUN) || (state == C_RUN) || (state == E_RUN);
   assign act_done   = in_run && ((bus.eng_done & act_sel) != 3'b000);
   assign wd_expired = in_run && (wdog == WD_LAST);
   assign start_ok   = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

   always_comb begin
      act_row = bus.eng_row[0 +: ADDR_W];
      act_col = bus.eng_col[0 +: ADDR_W];
      act_pix = bus.eng_pix[0 +: PIX_W];
      act_we  = bus.eng_we[0];
      case (act_sel)
         3'b010: begin
            act_row = bus.eng_row[ADDR_W +: ADDR_W];
            act_col = bus.eng_col[ADDR_W +: ADDR_W];
            act_pix = bus.eng_pix[PIX_W +: PIX_W];
            act_we  = bus.eng_we[1];
         end
         3'b100: begin
            act_row = bus.eng_row[2*ADDR_W +: ADDR_W];
            act_col = bus.eng_col[2*ADDR_W +: ADDR_W];
            act_pix = bus.eng_pix[2*PIX_W +: PIX_W];
            act_we  = bus.eng_we[2];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Done takes priority over the watchdog on the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERROR: if (start) state_nxt = G_ST;
         G_ST:  state_nxt = G_RUN;
         C_ST:  state_nxt = C_RUN;
         E_ST:  state_nxt = E_RUN;
         G_RUN: if (act_done) state_nxt = C_ST; else if (wd_expired) state_nxt = ERROR;
         C_RUN: if (act_done) state_nxt = E_ST; else if (wd_expired) state_nxt = ERROR;
         E_RUN: if (act_done) state_nxt = DONE; else if (wd_expired) state_nxt = ERROR;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      eng_start_nxt = 3'b000;
      case (state_nxt)
         G_ST:    eng_start_nxt = 3'b001;
         C_ST:    eng_start_nxt = 3'b010;
         E_ST:    eng_start_nxt = 3'b100;
         default: eng_start_nxt = 3'b000;
      endcase

      busy_nxt = !((state_nxt == IDLE) || (state_nxt == DONE) || (state_nxt == ERROR));

      done_nxt = done_q;
      err_nxt  = err;
      if (start_ok) begin
         done_nxt = 3'b000;
         err_nxt  = 1'b0;
      end
      if (act_done) done_nxt = done_q | act_sel;
      if (in_run && (state_nxt == ERROR)) err_nxt = 1'b1;

      // Counts only inside a RUN phase; saturates instead of wrapping.
      wdog_nxt = '0;
      if (in_run && !act_done) wdog_nxt = (wdog == WD_LAST) ? wdog : wdog + 1'b1;

      fwd = in_run && (state_nxt != ERROR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog          <= '0;
         done_q        <= 3'b000;
         err           <= 1'b0;
         busy          <= 1'b0;
         bus.eng_start <= 3'b000;
         bus.row       <= '0;
         bus.col       <= '0;
         bus.we        <= 1'b0;
         bus.out_pix   <= '0;
      end else begin
         wdog          <= wdog_nxt;
         done_q        <= done_nxt;
         err           <= err_nxt;
         busy          <= busy_nxt;
         bus.eng_start <= eng_start_nxt;
         bus.we        <= fwd && act_we;
         if (fwd) begin
            bus.row     <= act_row;
            bus.col     <= act_col;
            bus.out_pix <= act_pix;
         end
      end
   end
endmodule

// File: tb/tb_image_phase_scheduler.sv
// Directed bench: nominal run, isolation, spurious done, watchdog, collision, reset, busy start.
module tb_image_phase_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic wstart = 1'b0;
   logic gray_done, compress_done, encode_done, busy, err;
   logic wgray_done, wcompress_done, wencode_done, wbusy, werr;

   int n_tests = 0;
   int n_fail  = 0;
   logic [2:0] seq[$];

   image_phase_scheduler_if #(.ADDR_W(6), .PIX_W(24)) bus ();
   image_phase_scheduler_if #(.ADDR_W(6), .PIX_W(24)) wbus ();

   image_phase_scheduler #(.ADDR_W(6), .PIX_W(24), .TIMEOUT(65536)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
      .gray_done(gray_done), .compress_done(compress_done), .encode_done(encode_done),
      .busy(busy), .err(err)
   );

   image_phase_scheduler #(.ADDR_W(6), .PIX_W(24), .TIMEOUT(16)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(wstart), .bus(wbus),
      .gray_done(wgray_done), .compress_done(wcompress_done), .encode_done(wencode_done),
      .busy(wbusy), .err(werr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.eng_start != 3'b000) seq.push_back(bus.eng_start);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_eng();
      bus.eng_done = '0;  bus.eng_we = '0;  bus.eng_row = '0;
      bus.eng_col = '0;   bus.eng_pix = '0;
      wbus.eng_done = '0; wbus.eng_we = '0; wbus.eng_row = '0;
      wbus.eng_col = '0;  wbus.eng_pix = '0;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [11:0] a;
      logic [23:0] p;
      idle_eng();
      repeat (3) tick();
      check("rst_outs", {bus.eng_start, bus.row, bus.col, bus.we, bus.out_pix,
                         gray_done, compress_done, encode_done, busy, err}, 64'd0);
      check("rst_w_outs", {wbus.eng_start, wbus.we, wgray_done, wbusy, werr}, 64'd0);
      rst_n = 1'b1;
      tick();

      // ---- nominal run ----
      seq.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("g_st_start", bus.eng_start, 3'b001);
      check("g_st_busy", busy, 1'b1);
      tick();
      check("g_pulse_width", bus.eng_start, 3'b000);
      // engine 2 writes and engine 1 reports done while gray is quiet
      bus.eng_we[2] = 1'b1;
      bus.eng_row[12 +: 6] = 6'd5;
      bus.eng_col[12 +: 6] = 6'd7;
      bus.eng_pix[48 +: 24] = 24'hFFFFFF;
      bus.eng_done[1] = 1'b1;
      tick();
      bus.eng_done[1] = 1'b0;
      check("iso_we", bus.we, 1'b0);
      check("iso_addr", {bus.row, bus.col}, 12'd0);
      check("spur_cdone", compress_done, 1'b0);
      check("spur_no_cst", bus.eng_start, 3'b000);
      tick();
      check("iso_we2", bus.we, 1'b0);
      check("spur_busy_cdone", {busy, compress_done}, 2'b10);
      bus.eng_we[2] = 1'b0;
      bus.eng_pix = '0;
      bus.eng_row = '0;
      bus.eng_col = '0;

      for (int i = 0; i < 4096; i++) begin
         a = 12'(i);
         p = {a, ~a};
         bus.eng_we[0] = 1'b1;
         bus.eng_row[5:0] = a[11:6];
         bus.eng_col[5:0] = a[5:0];
         bus.eng_pix[23:0] = p;
         if (i == 4095) bus.eng_done[0] = 1'b1;
         tick();
         check("gray_wr", {bus.we, bus.row, bus.col, bus.out_pix}, {1'b1, a, p});
         if (i == 4094) check("gray_flag_early", gray_done, 1'b0);
      end
      idle_eng();
      check("gray_flag", gray_done, 1'b1);
      check("c_st_start", bus.eng_start, 3'b010);
      tick();
      check("c_st_we", bus.we, 1'b0);
      bus.eng_we = 3'b011;
      bus.eng_row = {6'd0, 6'd1, 6'd9};
      bus.eng_col = {6'd0, 6'd2, 6'd9};
      bus.eng_pix = {24'h0, 24'h123456, 24'h000000};
      tick();
      check("c_fwd", {bus.we, bus.row, bus.col, bus.out_pix}, {1'b1, 6'd1, 6'd2, 24'h123456});
      idle_eng();
      repeat (8) tick();
      bus.eng_done[1] = 1'b1;
      tick();
      bus.eng_done = '0;
      check("c_flags", {gray_done, compress_done, encode_done}, 3'b110);
      check("e_st_start", bus.eng_start, 3'b100);
      tick();
      repeat (19) tick();
      bus.eng_done[2] = 1'b1;
      tick();
      bus.eng_done = '0;
      check("done_flags_busy", {gray_done, compress_done, encode_done, busy}, 4'b1110);
      check("done_we_start", {bus.we, bus.eng_start}, 4'b0000);
      check("start_seq_n", seq.size(), 3);
      if (seq.size() == 3) check("start_seq", {seq[0], seq[1], seq[2]}, 9'b001_010_100);

      // ---- minimum 7-cycle run ----
      start = 1'b1;
      bus.eng_done = 3'b111;
      tick();
      start = 1'b0;
      check("min_flags_clr", {gray_done, compress_done, encode_done}, 3'b000);
      repeat (5) tick();
      check("min_t6", {busy, encode_done}, 2'b10);
      tick();
      check("min_t7", {busy, gray_done, compress_done, encode_done}, 4'b0111);
      idle_eng();

      // ---- async reset during an E_RUN write ----
      start = 1'b1;
      bus.eng_done = 3'b011;
      bus.eng_we = 3'b100;
      bus.eng_row[12 +: 6] = 6'd3;
      bus.eng_col[12 +: 6] = 6'd4;
      bus.eng_pix[48 +: 24] = 24'hABCDEF;
      tick();
      start = 1'b0;
      repeat (6) tick();
      check("e_run_wr", {bus.we, bus.row, bus.col, bus.out_pix, busy},
            {1'b1, 6'd3, 6'd4, 24'hABCDEF, 1'b1});
      #2 rst_n = 1'b0;
      #1;
      check("arst_outs", {bus.eng_start, bus.row, bus.col, bus.we, bus.out_pix,
                          gray_done, compress_done, encode_done, busy, err}, 64'd0);
      idle_eng();
      tick();
      rst_n = 1'b1;
      tick();

      // ---- start while busy is ignored ----
      seq.delete();
      start = 1'b1;
      bus.eng_done = 3'b001;
      tick();
      start = 1'b0;
      repeat (3) tick();
      bus.eng_done = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("busy_start_seq_n", seq.size(), 2);
      check("busy_start_state", {busy, gray_done, compress_done, err}, 4'b1100);

      // ---- watchdog, TIMEOUT=16, compress never finishes ----
      wstart = 1'b1;
      wbus.eng_done = 3'b001;
      wbus.eng_we = 3'b010;
      wbus.eng_row[6 +: 6] = 6'd2;
      tick();
      wstart = 1'b0;
      repeat (18) tick();
      check("wd_pre", {werr, wbus.we, wbusy}, 3'b011);
      tick();
      check("wd_err", {werr, wgray_done, wcompress_done, wbus.we, wbusy}, 5'b11000);
      idle_eng();
      wstart = 1'b1;
      wbus.eng_done = 3'b111;
      tick();
      wstart = 1'b0;
      check("wd_clr", {werr, wgray_done, wbusy}, 3'b001);
      repeat (6) tick();
      check("wd_rerun", {wencode_done, wbusy, werr}, 3'b100);
      idle_eng();

      // ---- done on the last watchdog cycle wins ----
      wstart = 1'b1;
      tick();
      wstart = 1'b0;
      tick();
      repeat (15) tick();
      wbus.eng_done[0] = 1'b1;
      tick();
      wbus.eng_done = '0;
      check("coll", {wgray_done, werr, wbus.eng_start}, {1'b1, 1'b0, 3'b010});
      tick();
      check("coll_after", {wbusy, werr}, 2'b10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/image_phase_scheduler.md
# image_phase_scheduler

Sequences the three processing engines (grayscale, compression, message encode) of the hiding pipeline and owns the single 64x64 image-memory write/address port between them. One `start` pulse runs gray → compress → encode in order. Only the active engine's address and write traffic reaches the image memory. The block raises the sticky `gray_done` / `compress_done` / `encode_done` flags consumed by the top level and the bench, and traps a stalled engine with a watchdog.

## Interface
- `ADDR_W`, 6, row/col width (64x64 image)
- `PIX_W`, 24, pixel width (RGB 8:8:8)
- `TIMEOUT`, 65536, max cycles an engine may run before error; must be ≥ 2

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse, begin a full run
- `eng_start` out 3: one-hot start pulse; bit0 gray, bit1 compress, bit2 encode
- `eng_done` in 3: one-cycle done pulse per engine, same bit order
- `eng_row` in 3*ADDR_W: per-engine row; engine k at bits [k*ADDR_W +: ADDR_W]
- `eng_col` in 3*ADDR_W: per-engine col, same packing
- `eng_we` in 3: per-engine write enable
- `eng_pix` in 3*PIX_W: per-engine write pixel
- `row`, `col` out ADDR_W each: image-memory address
- `we` out 1: image-memory write enable
- `out_pix` out PIX_W: image-memory write data
- `gray_done`, `compress_done`, `encode_done` out 1 each: sticky phase-complete flags
- `busy` out 1: run in progress
- `err` out 1: sticky watchdog error

## Operation
- FSM states: IDLE, G_ST, G_RUN, C_ST, C_RUN, E_ST, E_RUN, DONE, ERROR.
- IDLE / DONE / ERROR + `start`:
  - clear all three done flags, `err`, and the watchdog
  - go to G_ST
- `start` in any other state is ignored.
- X_ST:
  - `eng_start[k]`=1 for exactly this one cycle
  - `we`=0
  - next state X_RUN unconditionally
- X_RUN:
  - Mux registers the active engine's `eng_row/col/we/pix` into `row/col/we/out_pix` every cycle.
  - Inactive engines' inputs never reach the outputs.
  - Watchdog increments each cycle.
- X_RUN + `eng_done[k]` of the active engine:
  - set that engine's done flag
  - reset the watchdog
  - next state: G_RUN→C_ST, C_RUN→E_ST, E_RUN→DONE
- `eng_done` bits of inactive engines are ignored, with no flag change.
- Watchdog reaching TIMEOUT−1 in X_RUN without an active done:
  - go to ERROR, `err`=1, `we`=0
  - done flags already set are kept
- Done and timeout in the same cycle: done wins.
- `busy` = 1 in every state except IDLE, DONE, ERROR.
- Outside X_RUN, `we`=0.
  - `row`/`col`/`out_pix` hold their last value.
  - The memory therefore sees no writes between phases.
- Watchdog width is clog2(TIMEOUT); it saturates, never wraps.

## Timing
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- `rst_n` asserted mid-run:
  - immediate abort
  - all outputs 0, including `we` (a write in flight is dropped)
  - state IDLE
- `start` at cycle t:
  - G_ST at t+1, with `eng_start`=3'b001 and `busy`=1 visible at t+1
  - G_RUN at t+2
- Active-engine inputs at cycle c in X_RUN appear on `row/col/we/out_pix` at c+1.
  - This is one-cycle address/data latency; engines must account for it.
- `eng_done[k]` at cycle d:
  - flag high at d+1
  - next engine's `eng_start` pulse at d+1
  - next engine's traffic forwarded from d+2
- Inputs sampled on the last RUN cycle (the done cycle) are still forwarded at d+1.
- Minimum full run is 7 cycles from `start` to DONE (each engine done on its first RUN cycle).
  - `encode_done` and `busy`=0 both appear on the same edge as entering DONE.

## Test plan
- Nominal: `start`; gray done after 4096 writes, compress after 10 cycles, encode after 20 cycles.
  - Required: `eng_start` pulses 001, 010, 100, each exactly 1 cycle.
  - Required: flags rise in order and stay high; `busy` falls with `encode_done`.
  - Required: 4096 gray writes appear at memory, each 1 cycle late with identical row/col/pix.
- Isolation: during G_RUN drive `eng_we[2]`=1 with row=5, col=7, pix=24'hFFFFFF while gray holds `we`=0.
  - Required: `we` stays 0 and the memory is unchanged.
- Spurious done: pulse `eng_done[1]` during G_RUN.
  - Required: `compress_done` stays 0, state stays G_RUN.
- Watchdog: TIMEOUT=16, compress never done.
  - Required: `err`=1 exactly 16 cycles after C_RUN entry; `gray_done`=1, `compress_done`=0, `we`=0.
  - Then `start`: `err` clears and a full run completes.
- Done/timeout collision: assert `eng_done[0]` on the TIMEOUT−1 cycle.
  - Required: `gray_done`=1, `err`=0, C_ST follows.
- Reset mid-run and restart:
  - Deassert `rst_n` during E_RUN while `we`=1.
    - Required: all outputs 0 asynchronously, before the next edge.
  - `start` while `busy` (after a fresh `start`, in C_RUN).
    - Required: ignored, no extra `eng_start`.
